bm_log_sched: RTL and testbench

- Round-robin scheduler that shares one registered 32-bit bitwise-logic unit among NREQ requesters.
- Each requester presents operands a, b and a 3-bit opcode with a valid/ready handshake.
- The block arbitrates between requesters, executes the operation, and returns the result tagged with the requester ID on a single response channel with backpressure.
- It sits between the microbenchmark request sources and the shared logic datapath.

---
 rtl/bm_log_pkg.sv | 21 ++
 rtl/bm_log_sched_if.sv | 28 ++
 rtl/bm_log_rr_arbiter.sv | 31 +++
 rtl/bm_log_sched.sv | 100 ++++++++++
 tb/tb_bm_log_sched.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/bm_log_pkg.sv
// rtl/bm_log_pkg.sv - shared opcodes, FSM encoding and default width for the logic scheduler
package bm_log_pkg;

    localparam int BM_LOG_BITS = 32;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_XOR   = 3'd2;
    localparam logic [2:0] OP_XNOR  = 3'd3;
    localparam logic [2:0] OP_NAND  = 3'd4;
    localparam logic [2:0] OP_NOR   = 3'd5;
    localparam logic [2:0] OP_NOT   = 3'd6;
    localparam logic [2:0] OP_COMBO = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/bm_log_sched_if.sv
// rtl/bm_log_sched_if.sv - request/response bundle between requesters and the scheduler
interface bm_log_sched_if #(
    parameter int BITS = 32,
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [3*NREQ-1:0]    req_op;
    logic [BITS*NREQ-1:0] req_a;
    logic [BITS*NREQ-1:0] req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [BITS-1:0]      rsp_data;

    // Requester/consumer side
    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/bm_log_rr_arbiter.sv
// rtl/bm_log_rr_arbiter.sv - combinational round-robin grant starting after the last winner
module bm_log_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req_valid,
    input  logic [IDW-1:0]  i_last_grant,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_grant_idx
);

    int   w_cand;
    logic w_found;

    // Walk requesters from last_grant+1 (wrapping) and pick the first valid one
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_cand      = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = (int'(i_last_grant) + 1 + i) % NREQ;
            if (!w_found && i_req_valid[w_cand]) begin
                w_found         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_grant_idx     = IDW'(w_cand);
            end
        end
    end

endmodule

// File: rtl/bm_log_sched.sv
// rtl/bm_log_sched.sv - round-robin scheduler sharing one registered bitwise logic unit
import bm_log_pkg::*;

module bm_log_sched #(
    parameter int BITS = BM_LOG_BITS,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    bm_log_sched_if.slave bus
);

    state_t          r_state;
    logic [IDW-1:0]  r_last_grant;
    logic [IDW-1:0]  r_gnt;
    logic [2:0]      r_op;
    logic [BITS-1:0] r_a;
    logic [BITS-1:0] r_b;
    logic [BITS-1:0] r_result;
    logic            r_rsp_valid;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_grant_idx;
    logic [BITS-1:0] w_logic;

    bm_log_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .i_req_valid  (bus.req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx)
    );

    // Ready is only offered in IDLE; gating with reset_n keeps it low during an asserted reset
    assign bus.req_ready = (r_state == ST_IDLE && reset_n) ? w_grant : '0;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_gnt;
    assign bus.rsp_data  = r_result;

    // Shared bitwise logic unit operating on the captured operands
    always_comb begin
        w_logic = '0;
        case (r_op)
            OP_AND:   w_logic = r_a & r_b;
            OP_OR:    w_logic = r_a | r_b;
            OP_XOR:   w_logic = r_a ^ r_b;
            OP_XNOR:  w_logic = ~(r_a ^ r_b);
            OP_NAND:  w_logic = ~(r_a & r_b);
            OP_NOR:   w_logic = ~(r_a | r_b);
            OP_NOT:   w_logic = ~r_a;
            OP_COMBO: w_logic = (r_a & r_b) | (r_a ^ r_b) | (~r_a | r_b);
        endcase
    end

    // Accept -> execute -> respond; the priority pointer advances only on response handshake
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= IDW'(NREQ - 1);
            r_gnt        <= '0;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_result     <= '0;
            r_rsp_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|bus.req_valid) begin
                        r_gnt   <= w_grant_idx;
                        r_op    <= bus.req_op[int'(w_grant_idx)*3 +: 3];
                        r_a     <= bus.req_a[int'(w_grant_idx)*BITS +: BITS];
                        r_b     <= bus.req_b[int'(w_grant_idx)*BITS +: BITS];
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_result    <= w_logic;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid  <= 1'b0;
                        r_last_grant <= r_gnt;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bm_log_sched.sv
// tb/tb_bm_log_sched.sv - directed self-checking bench for bm_log_sched
module tb_bm_log_sched;
    import bm_log_pkg::*;

    localparam int BITS = 32;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    bm_log_sched_if #(.BITS(BITS), .NREQ(NREQ), .IDW(IDW)) bus ();

    bm_log_sched #(.BITS(BITS), .NREQ(NREQ), .IDW(IDW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_op[3*id +: 3]  = op;
        bus.req_a[32*id +: 32] = a;
        bus.req_b[32*id +: 32] = b;
    endtask

    task automatic drain();
        @(negedge clock);
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    // Single transaction from one requester; checks 2-cycle latency, id and data
    task automatic do_txn(input int id, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        logic [3:0] onehot;
        int k;
        onehot = 4'b0001 << id;
        @(negedge clock);
        set_req(id, op, a, b);
        bus.req_valid = onehot;
        bus.rsp_ready = 1'b1;
        #1;
        k = 0;
        while (bus.req_ready !== onehot && k < 8) begin
            @(negedge clock);
            #1;
            k++;
        end
        chk("txn_accept", 64'(bus.req_ready), 64'(onehot));
        @(posedge clock);
        #1;
        bus.req_valid = '0;
        @(negedge clock);
        chk("txn_exec_no_rsp", 64'(bus.rsp_valid), 64'd0);
        @(negedge clock);
        chk("txn_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("txn_rsp_id", 64'(bus.rsp_id), 64'(id));
        chk("txn_rsp_data", 64'(bus.rsp_data), 64'(exp));
        @(negedge clock);
        chk("txn_done", 64'(bus.rsp_valid), 64'd0);
    endtask

    logic [31:0] sweep_exp [8];
    int          exp_seq [5];
    int          ng;
    int          nr;
    int          gidx;
    logic [31:0] hold_data;

    initial begin
        checks = 0;
        errors = 0;
        sweep_exp = '{32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'hF00FF00F,
                      32'h0FFF0FFF, 32'h000F000F, 32'h0F0F0F0F, 32'hFFFFFFFF};
        exp_seq = '{0, 1, 2, 3, 0};

        // Reset with all requesters valid: ready must stay low, outputs cleared
        reset_n       = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++)
            set_req(i, OP_AND, 32'h11111111 * 32'(i + 1), 32'hFFFFFFFF);
        bus.req_valid = 4'hF;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);

        // Contention: grants and responses 0,1,2,3,0
        @(negedge clock);
        reset_n = 1'b1;
        ng = 0;
        nr = 0;
        for (int cyc = 0; cyc < 40 && (ng < 5 || nr < 5); cyc++) begin
            #1;
            chk("cont_onehot0", 64'($countones(bus.req_ready) <= 1), 64'd1);
            if (bus.req_ready != '0 && ng < 5) begin
                gidx = 0;
                for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) gidx = i;
                chk("cont_grant", 64'(gidx), 64'(exp_seq[ng]));
                ng++;
            end
            if (bus.rsp_valid && nr < 5) begin
                chk("cont_rsp_id", 64'(bus.rsp_id), 64'(exp_seq[nr]));
                chk("cont_rsp_data", 64'(bus.rsp_data), 64'(32'h11111111 * 32'(exp_seq[nr] + 1)));
                nr++;
            end
            @(negedge clock);
        end
        chk("cont_grant_count", 64'(ng), 64'd5);
        chk("cont_rsp_count", 64'(nr), 64'd5);
        drain();

        // Opcode sweep on requester 1
        for (int op = 0; op < 8; op++)
            do_txn(1, 3'(op), 32'hF0F0F0F0, 32'hFF00FF00, sweep_exp[op]);

        // Fairness skip: grant 0, then with 0 and 2 valid expect 2 then 0
        do_txn(0, OP_OR, 32'h00000001, 32'h00000002, 32'h00000003);
        @(negedge clock);
        set_req(0, OP_XOR, 32'hAAAAAAAA, 32'h0000FFFF);
        set_req(2, OP_XOR, 32'h55555555, 32'h0000FFFF);
        bus.req_valid = 4'b0101;
        ng = 0;
        for (int cyc = 0; cyc < 20 && ng < 2; cyc++) begin
            #1;
            if (bus.req_ready != '0) begin
                gidx = 0;
                for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) gidx = i;
                chk("fair_grant", 64'(gidx), (ng == 0) ? 64'd2 : 64'd0);
                ng++;
            end
            @(negedge clock);
        end
        chk("fair_grant_count", 64'(ng), 64'd2);
        drain();

        // Backpressure on requester 3 while others keep asking
        @(negedge clock);
        set_req(3, OP_XOR, 32'h12345678, 32'hFFFFFFFF);
        bus.req_valid = 4'b1000;
        bus.rsp_ready = 1'b0;
        #1;
        chk("bp_accept", 64'(bus.req_ready), 64'h8);
        @(posedge clock);
        #1;
        bus.req_valid = 4'b0111;
        @(negedge clock);
        @(negedge clock);
        chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("bp_rsp_id", 64'(bus.rsp_id), 64'd3);
        chk("bp_rsp_data", 64'(bus.rsp_data), 64'hEDCBA987);
        hold_data = bus.rsp_data;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            chk("bp_hold_valid", 64'(bus.rsp_valid), 64'd1);
            chk("bp_hold_id", 64'(bus.rsp_id), 64'd3);
            chk("bp_hold_data", 64'(bus.rsp_data), 64'(hold_data));
            chk("bp_no_ready", 64'(bus.req_ready), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("bp_release_valid", 64'(bus.rsp_valid), 64'd0);
        chk("bp_release_next_grant", 64'(bus.req_ready), 64'h1);
        bus.req_valid = '0;
        drain();

        // Reset during EXEC drops the transaction and restores priority to requester 0
        do_txn(0, OP_AND, 32'hFFFFFFFF, 32'h0000FFFF, 32'h0000FFFF);
        @(negedge clock);
        set_req(2, OP_NOT, 32'h0000FFFF, 32'h0);
        bus.req_valid = 4'b0100;
        #1;
        chk("rmid_accept", 64'(bus.req_ready), 64'h4);
        @(posedge clock);
        #1;
        for (int i = 0; i < NREQ; i++)
            set_req(i, OP_AND, 32'h11111111 * 32'(i + 1), 32'hFFFFFFFF);
        bus.req_valid = 4'hF;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("rmid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rmid_req_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clock);
        chk("rmid_rsp_data", 64'(bus.rsp_data), 64'd0);
        reset_n = 1'b1;
        #1;
        chk("rmid_first_grant", 64'(bus.req_ready), 64'h1);
        chk("rmid_no_stale", 64'(bus.rsp_valid), 64'd0);
        @(posedge clock);
        #1;
        bus.req_valid = '0;
        @(negedge clock);
        chk("rmid_exec_no_rsp", 64'(bus.rsp_valid), 64'd0);
        @(negedge clock);
        chk("rmid_rsp_valid2", 64'(bus.rsp_valid), 64'd1);
        chk("rmid_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("rmid_rsp_data2", 64'(bus.rsp_data), 64'h11111111);
        drain();

        // Idle: nothing requested for 20 cycles
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            chk("idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);
            chk("idle_req_ready", 64'(bus.req_ready), 64'd0);
        end
        chk("idle_state", 64'(dut.r_state), 64'(ST_IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
